// File: rtl/oryx_pkg.sv
// -----------------------------------------------------------------------------
// oryx_pkg
// Shared definitions for the oryx core write-back slice.
//   XLEN     : result / register-file data width
//   NREG     : number of architectural registers
//   REG_AW   : register index width (clog2(NREG))
//   wb_src_e : write-back result source (ALU or load unit)
//   wb_req_t : one write-back request (destination index + payload)
// -----------------------------------------------------------------------------
package oryx_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned NREG   = 32;
   localparam int unsigned REG_AW = 5;

   typedef enum logic {
      WB_SRC_ALU = 1'b0,
      WB_SRC_LD  = 1'b1
   } wb_src_e;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// -----------------------------------------------------------------------------
// wb_scoreboard
// Pending-write scoreboard: one busy bit per architectural register.
// Ports:
//   clk, rst              : clock, synchronous active-high reset (clears all)
//   set_i, set_idx_i      : mark set_idx_i busy on the next posedge
//   clr_i, clr_idx_i      : clear clr_idx_i on the next posedge
//   q1_idx_i, q2_idx_i    : hazard query indices
//   q1_busy_o, q2_busy_o  : busy state of the queried registers (current state)
// Register 0 is never busy. A set and a clear on the same index in the same
// cycle leaves the register busy.
// -----------------------------------------------------------------------------
module wb_scoreboard #(
   parameter int unsigned NREG = 32,
   parameter int unsigned AW   = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          set_i,
   input  logic [AW-1:0] set_idx_i,
   input  logic          clr_i,
   input  logic [AW-1:0] clr_idx_i,
   input  logic [AW-1:0] q1_idx_i,
   input  logic [AW-1:0] q2_idx_i,
   output logic          q1_busy_o,
   output logic          q2_busy_o
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   // Clear applied before set so that a same-cycle set on that index wins.
   always_comb begin
      busy_d = busy_q;
      if (clr_i) busy_d[clr_idx_i] = 1'b0;
      if (set_i) busy_d[set_idx_i] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // No bypass: queries see only the registered state.
   assign q1_busy_o = busy_q[q1_idx_i];
   assign q2_busy_o = busy_q[q2_idx_i];

endmodule

// File: rtl/wb_writer.sv
// -----------------------------------------------------------------------------
// wb_writer
// Write-side master for the register file. Accepts results from the ALU and
// the load unit over valid/ready, grants at most one per cycle and drives a
// registered write port. Tracks pending writes for RAW hazard detection.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   alu_valid/ready/rd/data    : ALU result handshake and payload
//   ld_valid/ready/rd/data     : load result handshake and payload
//   issue_valid, issue_rd      : decode issues an instruction writing issue_rd
//   q_r1, q_r2                 : hazard query indices
//   busy_r1, busy_r2           : pending write to q_r1 / q_r2 (combinational)
//   wr_en, w1, data            : registered register-file write port
//   stall_cnt                  : cycles in which a valid source was held off
// Build option:
//   WB_RR_ARB_EN : two-way round-robin arbitration between ALU and load unit.
//                  When undefined, the load unit has fixed priority.
// -----------------------------------------------------------------------------
module wb_writer #(
   parameter int unsigned XLEN = oryx_pkg::XLEN,
   parameter int unsigned NREG = oryx_pkg::NREG,
   parameter int unsigned AW   = oryx_pkg::REG_AW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [AW-1:0]   alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [AW-1:0]   ld_rd,
   input  logic [XLEN-1:0] ld_data,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   input  logic [AW-1:0]   q_r1,
   input  logic [AW-1:0]   q_r2,
   output logic            busy_r1,
   output logic            busy_r2,
   output logic            wr_en,
   output logic [AW-1:0]   w1,
   output logic [XLEN-1:0] data,
   output logic [31:0]     stall_cnt
);

   import oryx_pkg::*;

   logic            alu_gnt;
   logic            ld_gnt;
   wb_src_e         sel_src;
   logic [AW-1:0]   sel_rd;
   logic [XLEN-1:0] sel_data;
   logic            stall;

   logic            wr_en_d, wr_en_q;
   logic [AW-1:0]   w1_d,    w1_q;
   logic [XLEN-1:0] data_d,  data_q;
   logic [31:0]     stall_d, stall_q;

`ifdef WB_RR_ARB_EN
   wb_src_e         ptr_d, ptr_q;
`endif

   // Grant depends only on the valids (and pointer), never on payloads.
   always_comb begin
      alu_gnt = 1'b0;
      ld_gnt  = 1'b0;
      if (!rst) begin
`ifdef WB_RR_ARB_EN
         if (alu_valid && ld_valid) begin
            alu_gnt = (ptr_q == WB_SRC_ALU);
            ld_gnt  = (ptr_q == WB_SRC_LD);
         end else begin
            alu_gnt = alu_valid;
            ld_gnt  = ld_valid;
         end
`else
         ld_gnt  = ld_valid;
         alu_gnt = alu_valid && !ld_valid;
`endif
      end
   end

   assign alu_ready = alu_gnt;
   assign ld_ready  = ld_gnt;

   always_comb begin
      sel_src = ld_gnt ? WB_SRC_LD : WB_SRC_ALU;
      if (sel_src == WB_SRC_LD) begin
         sel_rd   = ld_rd;
         sel_data = ld_data;
      end else begin
         sel_rd   = alu_rd;
         sel_data = alu_data;
      end
   end

   assign stall = (alu_valid && !alu_gnt) || (ld_valid && !ld_gnt);

   // Writes to x0 are accepted but never reach the port; w1/data then hold.
   always_comb begin
      wr_en_d = (alu_gnt || ld_gnt) && (sel_rd != '0);
      w1_d    = w1_q;
      data_d  = data_q;
      if (wr_en_d) begin
         w1_d   = sel_rd;
         data_d = sel_data;
      end
      stall_d = stall ? stall_q + 32'd1 : stall_q;
   end

`ifdef WB_RR_ARB_EN
   // Only contended grants move the pointer.
   always_comb begin
      ptr_d = ptr_q;
      if (alu_valid && ld_valid && !rst) begin
         ptr_d = (ptr_q == WB_SRC_ALU) ? WB_SRC_LD : WB_SRC_ALU;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en_q <= 1'b0;
         w1_q    <= '0;
         data_q  <= '0;
         stall_q <= '0;
`ifdef WB_RR_ARB_EN
         ptr_q   <= WB_SRC_ALU;
`endif
      end else begin
         wr_en_q <= wr_en_d;
         w1_q    <= w1_d;
         data_q  <= data_d;
         stall_q <= stall_d;
`ifdef WB_RR_ARB_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   assign wr_en     = wr_en_q;
   assign w1        = w1_q;
   assign data      = data_q;
   assign stall_cnt = stall_q;

   wb_scoreboard #(
      .NREG (NREG),
      .AW   (AW)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .set_i     (issue_valid && (issue_rd != '0)),
      .set_idx_i (issue_rd),
      .clr_i     (wr_en_d),
      .clr_idx_i (sel_rd),
      .q1_idx_i  (q_r1),
      .q2_idx_i  (q_r2),
      .q1_busy_o (busy_r1),
      .q2_busy_o (busy_r2)
   );

endmodule
